// File: rtl/pc_redirect_unit.sv
// -----------------------------------------------------------------------------
// pc_redirect_unit
//
// Purpose:
//   Owns the fetch program counter for a simple in-order pipeline. It steps
//   the PC sequentially as instruction memory accepts requests, redirects it
//   to branch/JALR targets resolved in EX, squashes the younger pipeline
//   stages for a fixed number of cycles after each redirect, stalls fetch on
//   request from the hazard logic, and locks up in a trap state when a
//   redirect target is not word aligned.
//
// Parameters:
//   DATA_WIDTH    width of the PC and of all target buses
//   RESET_PC      first fetch address after reset
//   FLUSH_CYCLES  cycles flush_o stays high per redirect (1..7)
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   branch_taken   EX-stage conditional branch resolved taken
//   branch_target  EX-stage branch address (PC+imm), used unmodified
//   jalr_valid     EX-stage JALR executing (wins over branch_taken)
//   jalr_target    rs1+imm from the ALU; bit 0 is cleared before use
//   hold_pipeline  load-use / multi-cycle stall request
//   imem_ready     instruction memory accepts the current request
//   pc_o           current fetch address
//   pc_plus4_o     pc_o + 4, wrapping modulo 2^DATA_WIDTH
//   imem_req_o     fetch request valid
//   flush_o        squash IF/ID and ID/EX contents
//   redirect_o     one-cycle pulse in the first cycle at a new target
//   trap_o         misaligned-target trap, held until reset
// -----------------------------------------------------------------------------
module pc_redirect_unit #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h0000_0000,
  parameter int                    FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] branch_target,
  input  logic                  jalr_valid,
  input  logic [DATA_WIDTH-1:0] jalr_target,
  input  logic                  hold_pipeline,
  input  logic                  imem_ready,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic                  imem_req_o,
  output logic                  flush_o,
  output logic                  redirect_o,
  output logic                  trap_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2,
    TRAP  = 2'd3
  } state_t;

  // The counter holds the number of flush cycles still to come after the
  // current one, so a redirect loads FLUSH_CYCLES-1 and FLUSH exits at zero.
  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t                state_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [2:0]            cnt_q;
  logic                  flush_q;
  logic                  redirect_q;
  logic                  trap_q;

  logic                  redirect_req;
  logic [DATA_WIDTH-1:0] jalr_eff;
  logic [DATA_WIDTH-1:0] target;
  logic                  target_misaligned;
  logic [DATA_WIDTH-1:0] pc_next_seq;

  // Redirect target selection: JALR outranks a taken branch, and JALR's
  // target has bit 0 cleared as the ISA requires before alignment is judged.
  always_comb begin
    jalr_eff          = {jalr_target[DATA_WIDTH-1:1], 1'b0};
    redirect_req      = jalr_valid | branch_taken;
    target            = jalr_valid ? jalr_eff : branch_target;
    target_misaligned = (target[1:0] != 2'b00);
  end

  // Sequential PC step; the adder width makes the wrap at the top of the
  // address space implicit.
  assign pc_next_seq = pc_q + DATA_WIDTH'(4);

  // Main control FSM. A redirect outranks stalls and memory back-pressure in
  // every state except TRAP, which only reset can leave. flush_o, redirect_o
  // and trap_o are registered alongside the state so they line up with the
  // cycle in which pc_o shows the new target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      cnt_q      <= 3'd0;
      flush_q    <= 1'b0;
      redirect_q <= 1'b0;
      trap_q     <= 1'b0;
    end else begin
      redirect_q <= 1'b0;
      if (state_q == TRAP) begin
        trap_q  <= 1'b1;
        flush_q <= 1'b0;
      end else if (redirect_req) begin
        pc_q <= target;
        if (target_misaligned) begin
          state_q <= TRAP;
          trap_q  <= 1'b1;
          flush_q <= 1'b0;
          cnt_q   <= 3'd0;
        end else begin
          // A redirect inside FLUSH simply reloads the counter, extending
          // the squash window from the newest target.
          state_q    <= FLUSH;
          flush_q    <= 1'b1;
          redirect_q <= 1'b1;
          cnt_q      <= CNT_LOAD;
        end
      end else begin
        case (state_q)
          RUN: begin
            // A request accepted this cycle is complete, so the PC advances
            // on imem_ready even if a stall begins at the same edge.
            if (imem_ready) begin
              pc_q <= pc_next_seq;
            end
            if (hold_pipeline) begin
              state_q <= STALL;
            end
          end
          STALL: begin
            if (!hold_pipeline) begin
              state_q <= RUN;
            end
          end
          FLUSH: begin
            // Fetch keeps streaming from the new target while the older
            // stages are squashed; hold_pipeline only matters at exit.
            if (imem_ready) begin
              pc_q <= pc_next_seq;
            end
            if (cnt_q == 3'd0) begin
              flush_q <= 1'b0;
              state_q <= hold_pipeline ? STALL : RUN;
            end else begin
              cnt_q <= cnt_q - 3'd1;
            end
          end
          default: begin
            state_q <= state_q;
          end
        endcase
      end
    end
  end

  // The request is gated with rst_n so it drops immediately on reset and
  // rises in the first cycle after release, when state is already RUN.
  assign imem_req_o = rst_n & ((state_q == RUN) | (state_q == FLUSH));

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_next_seq;
  assign flush_o    = flush_q;
  assign redirect_o = redirect_q;
  assign trap_o     = trap_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_redirect_unit
//
// Purpose:
//   Directed, self-checking bench for pc_redirect_unit with default
//   parameters. Inputs change 1 ns after a rising edge; outputs are sampled
//   at that same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_pc_redirect_unit;

  logic        clk;
  logic        rst_n;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jalr_valid;
  logic [31:0] jalr_target;
  logic        hold_pipeline;
  logic        imem_ready;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        imem_req_o;
  logic        flush_o;
  logic        redirect_o;
  logic        trap_o;

  int total;
  int bad;

  pc_redirect_unit #(
    .DATA_WIDTH  (32),
    .RESET_PC    (32'h0000_0000),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jalr_valid   (jalr_valid),
    .jalr_target  (jalr_target),
    .hold_pipeline(hold_pipeline),
    .imem_ready   (imem_ready),
    .pc_o         (pc_o),
    .pc_plus4_o   (pc_plus4_o),
    .imem_req_o   (imem_req_o),
    .flush_o      (flush_o),
    .redirect_o   (redirect_o),
    .trap_o       (trap_o)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the bench always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value against its hand-computed expectation
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just past the edge
  task automatic apply_stimulus();
    @(posedge clk);
    #1;
  endtask

  // Check the full output set of one cycle
  task automatic check_all(input string tag, input logic [31:0] pc, input logic req,
                           input logic fl, input logic rd, input logic tr);
    check_output({tag, ".pc"}, pc_o, pc);
    check_output({tag, ".req"}, 32'(imem_req_o), 32'(req));
    check_output({tag, ".flush"}, 32'(flush_o), 32'(fl));
    check_output({tag, ".redir"}, 32'(redirect_o), 32'(rd));
    check_output({tag, ".trap"}, 32'(trap_o), 32'(tr));
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    jalr_valid    = 1'b0;
    jalr_target   = 32'h0;
    hold_pipeline = 1'b0;
    imem_ready    = 1'b1;

    // Reset held: everything at reset values, no request
    repeat (3) apply_stimulus();
    check_all("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Release reset away from the edge; sequential fetch from 0
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("rel", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output("rel.plus4", pc_plus4_o, 32'h4);
    apply_stimulus();
    check_all("seq1", 32'h4, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus();
    check_all("seq2", 32'h8, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus();
    check_all("seq3", 32'hC, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus();
    check_output("seq4.pc", pc_o, 32'h10);

    // Taken branch at 0x10 to 0x40
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    apply_stimulus();
    branch_taken  = 1'b0;
    check_all("br1", 32'h40, 1'b1, 1'b1, 1'b1, 1'b0);
    apply_stimulus();
    check_all("br2", 32'h44, 1'b1, 1'b1, 1'b0, 1'b0);
    apply_stimulus();
    check_all("br3", 32'h48, 1'b1, 1'b0, 1'b0, 1'b0);

    // Redirect to 0x20 with memory not ready: PC parks at 0x20
    branch_taken  = 1'b1;
    branch_target = 32'h20;
    imem_ready    = 1'b0;
    apply_stimulus();
    branch_taken  = 1'b0;
    check_all("nr1", 32'h20, 1'b1, 1'b1, 1'b1, 1'b0);
    apply_stimulus();
    check_all("nr2", 32'h20, 1'b1, 1'b1, 1'b0, 1'b0);
    apply_stimulus();
    check_all("nr3", 32'h20, 1'b1, 1'b0, 1'b0, 1'b0);

    // Stall for two cycles: request drops, PC holds
    hold_pipeline = 1'b1;
    apply_stimulus();
    check_all("st1", 32'h20, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus();
    check_all("st2", 32'h20, 1'b0, 1'b0, 1'b0, 1'b0);
    hold_pipeline = 1'b0;
    apply_stimulus();
    check_all("st3", 32'h20, 1'b1, 1'b0, 1'b0, 1'b0);
    imem_ready = 1'b1;
    apply_stimulus();
    check_output("st4.pc", pc_o, 32'h24);

    // JALR beats branch and hold; bit 0 of JALR target cleared
    jalr_valid    = 1'b1;
    jalr_target   = 32'h101;
    branch_taken  = 1'b1;
    branch_target = 32'h200;
    hold_pipeline = 1'b1;
    apply_stimulus();
    jalr_valid    = 1'b0;
    branch_taken  = 1'b0;
    check_all("jalr1", 32'h100, 1'b1, 1'b1, 1'b1, 1'b0);
    apply_stimulus();
    check_all("jalr2", 32'h104, 1'b1, 1'b1, 1'b0, 1'b0);
    // Flush expires with hold high: straight into STALL
    apply_stimulus();
    check_all("jalr3", 32'h108, 1'b0, 1'b0, 1'b0, 1'b0);
    hold_pipeline = 1'b0;
    apply_stimulus();
    check_all("jalr4", 32'h108, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus();
    check_output("jalr5.pc", pc_o, 32'h10C);

    // Wrap at the top of the address space
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    apply_stimulus();
    branch_taken  = 1'b0;
    check_output("wrap1.pc", pc_o, 32'hFFFF_FFFC);
    check_output("wrap1.plus4", pc_plus4_o, 32'h0);
    apply_stimulus();
    check_output("wrap2.pc", pc_o, 32'h0);
    check_output("wrap2.plus4", pc_plus4_o, 32'h4);
    apply_stimulus();
    check_all("wrap3", 32'h4, 1'b1, 1'b0, 1'b0, 1'b0);

    // Redirect to 0x60, then to 0x80 in the first flush cycle
    branch_taken  = 1'b1;
    branch_target = 32'h60;
    apply_stimulus();
    check_all("rr1", 32'h60, 1'b1, 1'b1, 1'b1, 1'b0);
    branch_target = 32'h80;
    apply_stimulus();
    branch_taken  = 1'b0;
    check_all("rr2", 32'h80, 1'b1, 1'b1, 1'b1, 1'b0);
    apply_stimulus();
    check_all("rr3", 32'h84, 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset mid-flush, checked before any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check_all("arst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("arel", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus();
    check_all("arel2", 32'h4, 1'b1, 1'b0, 1'b0, 1'b0);

    // Misaligned branch target traps and stays trapped
    branch_taken  = 1'b1;
    branch_target = 32'h42;
    apply_stimulus();
    check_all("trap0", 32'h42, 1'b0, 1'b0, 1'b0, 1'b1);
    branch_target = 32'h40;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus();
      check_output("trapN.trap", 32'(trap_o), 32'h1);
      check_output("trapN.req", 32'(imem_req_o), 32'h0);
      check_output("trapN.pc", pc_o, 32'h42);
    end
    branch_taken = 1'b0;

    // Only reset clears the trap
    #2;
    rst_n = 1'b0;
    #1;
    check_all("trst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus();
    check_all("trst2", 32'h4, 1'b1, 1'b0, 1'b0, 1'b0);

    // JALR whose cleared target is still misaligned also traps
    jalr_valid  = 1'b1;
    jalr_target = 32'h103;
    apply_stimulus();
    jalr_valid  = 1'b0;
    check_all("jtrap", 32'h102, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the PC and target width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 2, range 1..7, the number of cycles flush_o is asserted per redirect.
REQ-004 SHALL have port clk  input  1  clock; the block has one clock domain, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; it is asynchronous and active-low.
REQ-006 SHALL have port branch_taken  input  1  EX-stage conditional branch resolved taken.
REQ-007 SHALL have port branch_target  input  DATA_WIDTH  EX-stage branch address (PC+imm).
REQ-008 SHALL have port jalr_valid  input  1  EX-stage JALR executing.
REQ-009 SHALL have port jalr_target  input  DATA_WIDTH  rs1+imm from the ALU.
REQ-010 SHALL have port hold_pipeline  input  1  load-use or multi-cycle stall request.
REQ-011 SHALL have port imem_ready  input  1  instruction memory accepts the current request.
REQ-012 SHALL have port pc_o  output  DATA_WIDTH  current fetch address.
REQ-013 SHALL have port pc_plus4_o  output  DATA_WIDTH  pc_o+4, truncated to DATA_WIDTH.
REQ-014 SHALL have port imem_req_o  output  1  fetch request valid.
REQ-015 SHALL have port flush_o  output  1  squash IF/ID and ID/EX contents.
REQ-016 SHALL have port redirect_o  output  1  one-cycle pulse marking a PC redirect.
REQ-017 SHALL have port trap_o  output  1  misaligned-target trap, held high.

Function
REQ-018 SHALL implement the states RUN, STALL, FLUSH and TRAP, with the state and PC held in registers.
REQ-019 SHALL form the effective JALR target as jalr_target with bit 0 forced to 0; the branch target SHALL be used unmodified.
REQ-020 SHALL give jalr_valid priority over branch_taken when both are high in one cycle.
REQ-021 SHALL give a redirect priority over hold_pipeline and over imem_ready.
REQ-022 SHALL, on a redirect in RUN, STALL or FLUSH with an effective target[1:0]==0, load pc_o=target at the next edge.
REQ-023 SHALL, on that redirect, pulse redirect_o for exactly one cycle, the cycle after the edge, and enter FLUSH.
REQ-024 SHALL hold flush_o high for FLUSH_CYCLES consecutive cycles starting at the cycle in which pc_o=target.
REQ-025 SHALL restart the flush counter on a new redirect during FLUSH, so flush_o stays high FLUSH_CYCLES more cycles.
REQ-026 SHALL, in FLUSH, keep imem_req_o=1 and advance pc_o by 4 on imem_ready, so fetch from the new target continues.
REQ-027 SHALL, in FLUSH, ignore hold_pipeline, and return to RUN when the counter expires (or to STALL if hold_pipeline is high then).
REQ-028 SHALL, in RUN, drive imem_req_o=1, advance pc_o by 4 on an edge where imem_ready=1, and otherwise hold pc_o and the request stable.
REQ-029 SHALL enter STALL from RUN when hold_pipeline=1 with no redirect; STALL drives imem_req_o=0 and holds pc_o.
REQ-030 SHALL return from STALL to RUN on the first cycle with hold_pipeline=0.
REQ-031 SHALL enter TRAP on a redirect whose effective target[1:0]!=0.
REQ-032 In TRAP, pc_o SHALL keep the faulting target, and imem_req_o, flush_o and redirect_o SHALL all be 0.
REQ-033 SHALL assert trap_o in TRAP and leave TRAP only through reset.
REQ-034 SHALL wrap PC arithmetic modulo 2^DATA_WIDTH (0xFFFF_FFFC+4 gives 0x0000_0000), with no error flag.
REQ-035 SHALL ensure pc_o never changes in a cycle where imem_req_o=1 and imem_ready=0, except on a redirect.

Reset
REQ-036 SHALL, while rst_n=0, immediately force pc_o=RESET_PC, state=RUN, flush_counter=0, flush_o=0, redirect_o=0 and trap_o=0.
REQ-037 SHALL hold imem_req_o=0 during reset and drive imem_req_o=1 from the first cycle after rst_n rises.
REQ-038 SHALL abandon any redirect or flush in progress when reset asserts mid-operation; no redirect_o pulse SHALL follow deassertion.

Verification
REQ-039 Release reset with imem_ready=1 for 3 cycles -> pc_o = 0x0, 0x4, 0x8, 0xC on successive cycles; flush_o=0.
REQ-040 At pc 0x10, pulse branch_taken=1 with branch_target=0x40 -> next cycle pc_o=0x40 and redirect_o=1; flush_o=1 for 2 cycles; then pc_o=0x48.
REQ-041 In one cycle, assert jalr_valid with jalr_target=0x101, branch_taken with target 0x200, and hold_pipeline=1 -> pc_o=0x100 and FLUSH entered.
REQ-042 Set imem_ready=0 for 3 cycles at pc 0x20, then hold_pipeline=1 for 2 cycles -> pc_o stays 0x20 throughout, and imem_req_o=0 only while hold_pipeline=1.
REQ-043 Pulse branch_taken with target 0x42 -> trap_o=1 and imem_req_o=0 persist for at least 10 cycles; rst_n low clears them and pc_o=0x0.
REQ-044 Issue a second redirect to 0x80 in the first FLUSH cycle, then pull rst_n low mid-FLUSH -> flush_o is high 2 cycles after the 0x80 redirect, and all outputs take reset values asynchronously.
